// File: rtl/mini_alu_param.sv
// mini_alu_param: parametrised two-stage (fetch / execute) mini processor core.
// Holds an internal dual-read register file, an LED output register and a
// shift-add multiplier that stalls fetch for DATA_WIDTH cycles.
//
// Ports:
//   Clock        - single clock, all state updates on its rising edge
//   Reset        - asynchronous, active-high reset
//   oIP          - address of the instruction being fetched
//   iInstruction - {op[3:0], dest, src1, src0}, valid in the same cycle as oIP
//   oLed         - LED register
//   oBusy        - high while a MUL occupies the execute stage
//   oHalted      - high after HALT executes
module mini_alu_param #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned IP_WIDTH   = 16,
    parameter int unsigned LED_WIDTH  = 8
) (
    input  logic                        Clock,
    input  logic                        Reset,
    output logic [IP_WIDTH-1:0]         oIP,
    input  logic [4+3*ADDR_WIDTH-1:0]   iInstruction,
    output logic [LED_WIDTH-1:0]        oLed,
    output logic                        oBusy,
    output logic                        oHalted
);

    localparam int unsigned INSTR_W = 4 + 3 * ADDR_WIDTH;
    localparam int unsigned DEPTH   = 2 ** ADDR_WIDTH;
    localparam int unsigned SH_W    = $clog2(DATA_WIDTH);
    localparam int unsigned CNT_W   = $clog2(DATA_WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_STO  = 4'd4;
    localparam logic [3:0] OP_BLE  = 4'd5;
    localparam logic [3:0] OP_JMP  = 4'd6;
    localparam logic [3:0] OP_LED  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd12;

    // ST_MUL covers the second and later multiplier cycles; the first runs in ST_RUN
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MUL  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [IP_WIDTH-1:0]     ip, ip_next;
    logic [INSTR_W-1:0]      ir, ir_next;
    logic [LED_WIDTH-1:0]    led, led_next;
    logic                    busy, busy_next;
    logic                    halted, halted_next;
    logic [CNT_W-1:0]        mul_cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   mul_a, a_next;
    logic [DATA_WIDTH-1:0]   mul_b, b_next;
    logic [DATA_WIDTH-1:0]   mul_acc, acc_next;
    logic [DATA_WIDTH-1:0]   regs [DEPTH];

    logic                    we;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic [DATA_WIDTH-1:0]   wdata;

    logic [3:0]              op;
    logic [ADDR_WIDTH-1:0]   dest, src1, src0;
    logic [DATA_WIDTH-1:0]   rs0, rs1, imm;
    logic [2*ADDR_WIDTH-1:0] imm_raw;
    logic [IP_WIDTH-1:0]     target;
    logic [DATA_WIDTH-1:0]   a_cur, b_cur, acc_cur, acc_step;

    // Instruction field decode and register-file reads
    assign op      = ir[INSTR_W-1 -: 4];
    assign dest    = ir[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign src1    = ir[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
    assign src0    = ir[ADDR_WIDTH-1:0];
    assign rs0     = regs[src0];
    assign rs1     = regs[src1];
    assign imm_raw = {src1, src0};
    assign imm     = DATA_WIDTH'(imm_raw);
    assign target  = IP_WIDTH'(dest);

    // Multiplier datapath: first cycle takes operands straight from the register file
    assign a_cur    = (state == ST_MUL) ? mul_a   : rs1;
    assign b_cur    = (state == ST_MUL) ? mul_b   : rs0;
    assign acc_cur  = (state == ST_MUL) ? mul_acc : '0;
    assign acc_step = acc_cur + (b_cur[0] ? a_cur : '0);

    // Next-state, fetch and execute logic
    always_comb begin
        state_next  = state;
        ip_next     = ip;
        ir_next     = ir;
        led_next    = led;
        halted_next = halted;
        cnt_next    = mul_cnt;
        a_next      = mul_a;
        b_next      = mul_b;
        acc_next    = mul_acc;
        we          = 1'b0;
        waddr       = dest;
        wdata       = '0;

        case (state)
            ST_RUN: begin
                ip_next = ip + IP_WIDTH'(1);
                ir_next = iInstruction;
                case (op)
                    OP_ADD: begin
                        we    = 1'b1;
                        wdata = rs1 + rs0;
                    end
                    OP_SUB: begin
                        we    = 1'b1;
                        wdata = rs1 - rs0;
                    end
                    OP_MUL: begin
                        ip_next    = ip;
                        ir_next    = ir;
                        state_next = ST_MUL;
                        cnt_next   = CNT_W'(1);
                        a_next     = a_cur << 1;
                        b_next     = b_cur >> 1;
                        acc_next   = acc_step;
                    end
                    OP_STO: begin
                        we    = 1'b1;
                        wdata = imm;
                    end
                    OP_BLE: begin
                        if ($signed(rs1) <= $signed(rs0)) begin
                            ip_next = target;
                            ir_next = '0;
                        end
                    end
                    OP_JMP: begin
                        ip_next = target;
                        ir_next = '0;
                    end
                    OP_LED: led_next = rs1[LED_WIDTH-1:0];
                    OP_AND: begin
                        we    = 1'b1;
                        wdata = rs1 & rs0;
                    end
                    OP_OR: begin
                        we    = 1'b1;
                        wdata = rs1 | rs0;
                    end
                    OP_SHL: begin
                        we    = 1'b1;
                        wdata = rs1 << rs0[SH_W-1:0];
                    end
                    OP_BEQ: begin
                        if (rs1 == rs0) begin
                            ip_next = target;
                            ir_next = '0;
                        end
                    end
                    OP_HALT: begin
                        ip_next     = ip;
                        ir_next     = '0;
                        halted_next = 1'b1;
                        state_next  = ST_HALT;
                    end
                    default: ;
                endcase
            end
            ST_MUL: begin
                a_next   = a_cur << 1;
                b_next   = b_cur >> 1;
                acc_next = acc_step;
                cnt_next = mul_cnt + CNT_W'(1);
                // Last multiplier cycle: retire the result and resume fetch
                if (mul_cnt == CNT_W'(DATA_WIDTH - 1)) begin
                    we         = 1'b1;
                    wdata      = acc_step;
                    ip_next    = ip + IP_WIDTH'(1);
                    ir_next    = iInstruction;
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_HALT: ;
            default: state_next = ST_RUN;
        endcase
    end

    // Busy mirrors "a MUL sits in IR" for the coming cycle
    assign busy_next = (ir_next[INSTR_W-1 -: 4] == OP_MUL);

    // State, pipeline and register-file update
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state   <= ST_RUN;
            ip      <= '0;
            ir      <= '0;
            led     <= '0;
            busy    <= 1'b0;
            halted  <= 1'b0;
            mul_cnt <= '0;
            mul_a   <= '0;
            mul_b   <= '0;
            mul_acc <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state   <= state_next;
            ip      <= ip_next;
            ir      <= ir_next;
            led     <= led_next;
            busy    <= busy_next;
            halted  <= halted_next;
            mul_cnt <= cnt_next;
            mul_a   <= a_next;
            mul_b   <= b_next;
            mul_acc <= acc_next;
            if (we) begin
                regs[waddr] <= wdata;
            end
        end
    end

    assign oIP     = ip;
    assign oLed    = led;
    assign oBusy   = busy;
    assign oHalted = halted;

endmodule

// File: tb/tb_mini_alu_param.sv
// tb_mini_alu_param: directed self-checking bench for mini_alu_param.
// Instance dut uses default parameters; dut2 uses DATA_WIDTH=8, ADDR_WIDTH=4.
module tb_mini_alu_param;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_MUL  = 4'd3;
    localparam logic [3:0] OP_STO  = 4'd4;
    localparam logic [3:0] OP_BLE  = 4'd5;
    localparam logic [3:0] OP_LED  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_SHL  = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_HALT = 4'd12;

    logic        clk;
    logic        rst;
    logic        rst2;
    logic [15:0] ip;
    logic [27:0] instr;
    logic [7:0]  led;
    logic        busy;
    logic        halted;
    logic [7:0]  ip2;
    logic [15:0] instr2;
    logic [7:0]  led2;
    logic        busy2;
    logic        halted2;

    logic [27:0] imem  [256];
    logic [15:0] imem2 [16];

    int checks = 0;
    int passes = 0;

    assign instr  = imem[ip[7:0]];
    assign instr2 = imem2[ip2[3:0]];

    mini_alu_param dut (
        .Clock        (clk),
        .Reset        (rst),
        .oIP          (ip),
        .iInstruction (instr),
        .oLed         (led),
        .oBusy        (busy),
        .oHalted      (halted)
    );

    mini_alu_param #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .IP_WIDTH   (8),
        .LED_WIDTH  (8)
    ) dut2 (
        .Clock        (clk),
        .Reset        (rst2),
        .oIP          (ip2),
        .iInstruction (instr2),
        .oLed         (led2),
        .oBusy        (busy2),
        .oHalted      (halted2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [27:0] enc(input logic [3:0] op, input logic [7:0] d,
                                        input logic [7:0] s1, input logic [7:0] s0);
        return {op, d, s1, s0};
    endfunction

    function automatic logic [27:0] enc_imm(input logic [7:0] d, input logic [15:0] imm);
        return {OP_STO, d, imm};
    endfunction

    function automatic logic [15:0] enc8(input logic [3:0] op, input logic [3:0] d,
                                         input logic [3:0] s1, input logic [3:0] s0);
        return {op, d, s1, s0};
    endfunction

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset, clear program memory; caller loads a program then calls release_rst
    task automatic hold_rst();
        rst = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = '0;
        @(negedge clk);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Program: add 5+7, show on LED, halt
    task automatic load_straight();
        imem[0] = enc_imm(8'd1, 16'd5);
        imem[1] = enc_imm(8'd2, 16'd7);
        imem[2] = enc(OP_ADD, 8'd3, 8'd2, 8'd1);
        imem[3] = enc(OP_LED, 8'd0, 8'd3, 8'd0);
        imem[4] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
    endtask

    // Program: 300*250, show low byte on LED, halt
    task automatic load_mul();
        imem[0] = enc_imm(8'd1, 16'd300);
        imem[1] = enc_imm(8'd2, 16'd250);
        imem[2] = enc(OP_MUL, 8'd3, 8'd1, 8'd2);
        imem[3] = enc(OP_LED, 8'd0, 8'd3, 8'd0);
        imem[4] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rst2 = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = '0;
        for (int i = 0; i < 16; i++) imem2[i] = '0;
        #3;
        checks++;
        if ({ip, led, busy, halted} !== 26'd0)
            $display("FAIL reset_outputs: got ip=%0h led=%0h busy=%0b halted=%0b expected all 0",
                     ip, led, busy, halted);
        else passes++;
        load_straight();
        release_rst();
        checks++;
        if (ip !== 16'd0) $display("FAIL reset_cycle0_ip: got %0h expected 0", ip);
        else passes++;
    endtask

    task automatic test_straight_line();
        run(1);
        checks++;
        if (ip !== 16'd1) $display("FAIL straight_ip1: got %0h expected 1", ip);
        else passes++;
        run(3);
        checks++;
        if (ip !== 16'd4 || led !== 8'd0)
            $display("FAIL straight_pre_led: got ip=%0h led=%0h expected ip=4 led=0", ip, led);
        else passes++;
        run(1);
        checks++;
        if (led !== 8'd12 || ip !== 16'd5)
            $display("FAIL straight_led: got led=%0d ip=%0h expected led=12 ip=5", led, ip);
        else passes++;
        run(1);
        checks++;
        if (halted !== 1'b1) $display("FAIL straight_halt: got %0b expected 1", halted);
        else passes++;
        run(3);
        checks++;
        if (ip !== 16'd5 || halted !== 1'b1 || led !== 8'd12 || dut.regs[3] !== 16'd12)
            $display("FAIL straight_frozen: got ip=%0h halted=%0b led=%0d r3=%0d expected 5 1 12 12",
                     ip, halted, led, dut.regs[3]);
        else passes++;
    endtask

    task automatic test_wrap_ble();
        hold_rst();
        imem[0] = enc_imm(8'd1, 16'h7FFF);
        imem[1] = enc_imm(8'd2, 16'h0001);
        imem[2] = enc(OP_ADD, 8'd3, 8'd1, 8'd2);
        imem[3] = enc(OP_BLE, 8'd7, 8'd3, 8'd2);
        imem[4] = enc_imm(8'd4, 16'h0055);
        imem[5] = enc_imm(8'd5, 16'h0055);
        imem[7] = enc_imm(8'd6, 16'h0066);
        imem[8] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
        release_rst();
        run(5);
        checks++;
        if (ip !== 16'd7) $display("FAIL ble_target_ip: got %0h expected 7", ip);
        else passes++;
        run(3);
        checks++;
        if (dut.regs[3] !== 16'h8000) $display("FAIL wrap_add: got %0h expected 8000", dut.regs[3]);
        else passes++;
        checks++;
        if (dut.regs[4] !== 16'd0 || dut.regs[5] !== 16'd0)
            $display("FAIL ble_squash: got r4=%0h r5=%0h expected 0 0", dut.regs[4], dut.regs[5]);
        else passes++;
        checks++;
        if (dut.regs[6] !== 16'h0066 || halted !== 1'b1)
            $display("FAIL ble_target_exec: got r6=%0h halted=%0b expected 66 1", dut.regs[6], halted);
        else passes++;
    endtask

    task automatic test_logic_beq();
        hold_rst();
        imem[0] = enc_imm(8'd1, 16'h0F0C);
        imem[1] = enc_imm(8'd2, 16'h00FF);
        imem[2] = enc(OP_AND, 8'd3, 8'd1, 8'd2);
        imem[3] = enc(OP_OR,  8'd4, 8'd1, 8'd2);
        imem[4] = enc(OP_BEQ, 8'd9, 8'd3, 8'd4);
        imem[5] = enc(OP_SUB, 8'd5, 8'd2, 8'd1);
        imem[6] = enc(OP_BEQ, 8'd9, 8'd1, 8'd1);
        imem[7] = enc_imm(8'd6, 16'd1);
        imem[8] = enc_imm(8'd7, 16'd1);
        imem[9] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
        release_rst();
        run(8);
        checks++;
        if (ip !== 16'd9) $display("FAIL beq_target_ip: got %0h expected 9", ip);
        else passes++;
        run(1);
        checks++;
        if (halted !== 1'b0) $display("FAIL beq_halt_early: got %0b expected 0", halted);
        else passes++;
        run(1);
        checks++;
        if (halted !== 1'b1) $display("FAIL beq_halt: got %0b expected 1", halted);
        else passes++;
        checks++;
        if (dut.regs[3] !== 16'h000C || dut.regs[4] !== 16'h0FFF || dut.regs[5] !== 16'hF1F3)
            $display("FAIL logic_results: got and=%0h or=%0h sub=%0h expected c fff f1f3",
                     dut.regs[3], dut.regs[4], dut.regs[5]);
        else passes++;
        checks++;
        if (dut.regs[6] !== 16'd0 || dut.regs[7] !== 16'd0)
            $display("FAIL beq_squash: got r6=%0h r7=%0h expected 0 0", dut.regs[6], dut.regs[7]);
        else passes++;
    endtask

    task automatic test_loop();
        hold_rst();
        imem[0] = enc_imm(8'd4, 16'd9);
        imem[1] = enc_imm(8'd3, 16'd1);
        imem[2] = enc(OP_ADD, 8'd1, 8'd1, 8'd3);
        imem[3] = enc(OP_BLE, 8'd2, 8'd1, 8'd4);
        imem[4] = enc(OP_HALT, 8'd0, 8'd0, 8'd0);
        release_rst();
        run(32);
        checks++;
        if (halted !== 1'b0) $display("FAIL loop_halt_early: got %0b expected 0", halted);
        else passes++;
        run(1);
        checks++;
        if (halted !== 1'b1) $display("FAIL loop_halt_cycle: got %0b expected 1", halted);
        else passes++;
        checks++;
        if (dut.regs[1] !== 16'd10 || ip !== 16'd5)
            $display("FAIL loop_count: got r1=%0d ip=%0h expected 10 5", dut.regs[1], ip);
        else passes++;
    endtask

    task automatic test_mul();
        int busy_cycles = 0;
        int first_busy = -1;
        int last_busy = -1;
        int ip_bad = 0;
        hold_rst();
        load_mul();
        release_rst();
        for (int n = 1; n <= 22; n++) begin
            run(1);
            if (busy === 1'b1) begin
                busy_cycles++;
                if (first_busy < 0) first_busy = n;
                last_busy = n;
                if (ip !== 16'd3) ip_bad++;
            end
            if (n == 19) begin
                checks++;
                if (busy !== 1'b0 || ip !== 16'd4 || dut.regs[3] !== 16'd9464)
                    $display("FAIL mul_retire: got busy=%0b ip=%0h r3=%0d expected 0 4 9464",
                             busy, ip, dut.regs[3]);
                else passes++;
            end
        end
        checks++;
        if (busy_cycles != 16 || first_busy != 3 || last_busy != 18)
            $display("FAIL mul_busy_window: got cycles=%0d first=%0d last=%0d expected 16 3 18",
                     busy_cycles, first_busy, last_busy);
        else passes++;
        checks++;
        if (ip_bad != 0) $display("FAIL mul_ip_stall: got %0d moving cycles expected 0", ip_bad);
        else passes++;
        checks++;
        if (led !== 8'hF8 || halted !== 1'b1)
            $display("FAIL mul_led: got led=%0h halted=%0b expected f8 1", led, halted);
        else passes++;
    endtask

    task automatic test_reset_mid_mul();
        hold_rst();
        load_mul();
        release_rst();
        run(7);
        checks++;
        if (busy !== 1'b1) $display("FAIL midmul_busy: got %0b expected 1", busy);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ip, led, busy, halted} !== 26'd0 || dut.regs[1] !== 16'd0 ||
            dut.regs[2] !== 16'd0 || dut.mul_cnt !== 4'd0)
            $display("FAIL midmul_reset: got ip=%0h led=%0h busy=%0b r1=%0d r2=%0d cnt=%0d expected all 0",
                     ip, led, busy, dut.regs[1], dut.regs[2], dut.mul_cnt);
        else passes++;
        release_rst();
        run(20);
        checks++;
        if (led !== 8'hF8 || dut.regs[3] !== 16'd9464)
            $display("FAIL midmul_restart: got led=%0h r3=%0d expected f8 9464", led, dut.regs[3]);
        else passes++;
        run(2);
        checks++;
        if (halted !== 1'b1) $display("FAIL restart_halt: got %0b expected 1", halted);
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({ip, led, busy, halted} !== 26'd0 || dut.regs[3] !== 16'd0)
            $display("FAIL halt_reset: got ip=%0h led=%0h halted=%0b r3=%0d expected all 0",
                     ip, led, halted, dut.regs[3]);
        else passes++;
        release_rst();
        run(3);
        checks++;
        if (ip !== 16'd3 || dut.regs[1] !== 16'd300)
            $display("FAIL halt_restart: got ip=%0h r1=%0d expected 3 300", ip, dut.regs[1]);
        else passes++;
    endtask

    task automatic test_param_sweep();
        int busy_cycles = 0;
        int first_busy = -1;
        rst = 1'b1;
        imem2[0] = enc8(OP_STO, 4'd1, 4'hF, 4'hF);
        imem2[1] = enc8(OP_MUL, 4'd2, 4'd1, 4'd1);
        imem2[2] = enc8(OP_STO, 4'd3, 4'd0, 4'd1);
        imem2[3] = enc8(OP_STO, 4'd4, 4'd0, 4'd7);
        imem2[4] = enc8(OP_SHL, 4'd5, 4'd3, 4'd4);
        imem2[5] = enc8(OP_LED, 4'd0, 4'd5, 4'd0);
        imem2[6] = enc8(OP_HALT, 4'd0, 4'd0, 4'd0);
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        for (int n = 1; n <= 16; n++) begin
            run(1);
            if (busy2 === 1'b1) begin
                busy_cycles++;
                if (first_busy < 0) first_busy = n;
            end
        end
        checks++;
        if (busy_cycles != 8 || first_busy != 2)
            $display("FAIL w8_busy: got cycles=%0d first=%0d expected 8 2", busy_cycles, first_busy);
        else passes++;
        checks++;
        if (dut2.regs[2] !== 8'h01) $display("FAIL w8_mul: got %0h expected 01", dut2.regs[2]);
        else passes++;
        checks++;
        if (dut2.regs[5] !== 8'h80 || led2 !== 8'h80)
            $display("FAIL w8_shl: got r5=%0h led=%0h expected 80 80", dut2.regs[5], led2);
        else passes++;
        checks++;
        if (halted2 !== 1'b1) $display("FAIL w8_halt: got %0b expected 1", halted2);
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        test_reset();
        test_straight_line();
        test_wrap_ble();
        test_logic_beq();
        test_loop();
        test_mul();
        test_reset_mid_mul();
        test_param_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog: every test is a fixed-length directed sequence
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
